seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a common-segment N-digit 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-segment
// N-digit 7-segment display.
//   sys_clk, sys_rst_n : clock (rising edge) and asynchronous active-low reset
//   load, data_in      : 1-cycle strobe capturing a hex value (nibble i -> digit i)
//   digit_en, lz_en    : per-digit enable, leading-zero suppression enable
//   seg_data, sel_n    : registered active-low segments and digit selects
//   frame_done         : 1-cycle pulse during the last cycle of the last slot
//   pending            : a loaded value is waiting for the next frame boundary
// Each slot is CLK_DIV cycles: BLANK_CYC cycles with all digits off (anti-ghosting),
// then the digit is shown. The displayed value only changes at frame boundaries.

module seg_scan_hex7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // Active-low segments, bit order g..a.
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_en,
  output logic [6:0]            seg_data,
  output logic [DIGITS-1:0]     sel_n,
  output logic                  frame_done,
  output logic                  pending
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_n_q, sel_n_d;
  logic                frame_done_q, frame_done_d;

  logic                timer_wrap, last_idx, boundary, suppress;
  logic [DIGITS-1:0]   upper_zero;
  logic [6:0]          dec_seg;

  // State register (scan position + FSM)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_BLANK;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    timer_wrap = (timer_q == TW'(CLK_DIV-1));
    last_idx   = (idx_q == IW'(DIGITS-1));
    boundary   = timer_wrap && last_idx;
    timer_d    = timer_wrap ? '0 : timer_q + TW'(1);
    idx_d      = idx_q;
    if (timer_wrap) idx_d = last_idx ? '0 : idx_q + IW'(1);
    state_d    = state_q;
    case (state_q)
      ST_BLANK: if (timer_q == TW'(BLANK_CYC-1)) state_d = ST_SHOW;
      ST_SHOW:  if (timer_wrap) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Double buffer: a load landing on the boundary cycle bypasses pend_q.
  always_comb begin
    pend_d    = pend_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (load) begin
      pend_d    = data_in;
      pending_d = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        disp_d    = data_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 of the displayed value are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (disp_q[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = DIGITS-2; i >= 0; i--)
      upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'h0);
  end

  seg_scan_hex7 u_dec (
    .nib (disp_q[4*idx_d +: 4]),
    .seg (dec_seg)
  );

  // Output logic: computed from the upcoming state so the registered outputs
  // change on the same edge the state is entered.
  always_comb begin
    suppress     = lz_en && (idx_d != '0) && upper_zero[idx_d];
    sel_n_d      = '1;
    seg_d        = 7'h7F;
    frame_done_d = (timer_d == TW'(CLK_DIV-1)) && (idx_d == IW'(DIGITS-1));
    if (state_d == ST_SHOW) begin
      if (digit_en[idx_d]) sel_n_d[idx_d] = 1'b0;
      seg_d = suppress ? 7'h7F : dec_seg;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp_q       <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      sel_n_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      sel_n_q      <= sel_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_data   = seg_q;
  assign sel_n      = sel_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_en = 1'b0;
  logic [6:0]  seg_data;
  logic [3:0]  sel_n;
  logic        frame_done;
  logic        pending;

  int total = 0;
  int bad = 0;

  seg_scan_ctrl #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (load),
    .data_in    (data_in),
    .digit_en   (digit_en),
    .lz_en      (lz_en),
    .seg_data   (seg_data),
    .sel_n      (sel_n),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_fd(input int bound);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("wait_frame_done", 16'(frame_done), 16'h1);
  endtask

  // Called at timer 0 of slot 0; returns at timer 0 of the next frame.
  // es = {d3,d2,d1,d0} expected segments; la/lb = slots with a mid-slot load;
  // bnd = load on the frame-boundary cycle.
  task automatic frame_check(input logic [3:0][6:0] es,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input bit bnd, input logic [15:0] vbnd);
    logic [3:0] esel;
    for (int d = 0; d < 4; d++) begin
      esel = digit_en[d] ? ~(4'b0001 << d) : 4'hF;
      chk($sformatf("d%0d_blank0_sel", d), 16'(sel_n), 16'hF);
      chk($sformatf("d%0d_blank0_seg", d), 16'(seg_data), 16'h7F);
      tick();
      chk($sformatf("d%0d_blank1_sel", d), 16'(sel_n), 16'hF);
      tick();
      chk($sformatf("d%0d_show_sel", d), 16'(sel_n), 16'(esel));
      chk($sformatf("d%0d_show_seg", d), 16'(seg_data), 16'(es[d]));
      if (d == la || d == lb) begin
        data_in = (d == la) ? va : vb;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk($sformatf("d%0d_pending_after_load", d), 16'(pending), 16'h1);
        repeat (4) tick();
      end else begin
        repeat (5) tick();
      end
      chk($sformatf("d%0d_end_sel", d), 16'(sel_n), 16'(esel));
      chk($sformatf("d%0d_end_seg", d), 16'(seg_data), 16'(es[d]));
      chk($sformatf("d%0d_frame_done", d), 16'(frame_done), 16'(d == 3));
      if (d == 3 && bnd) begin
        data_in = vbnd;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("boundary_load_pending", 16'(pending), 16'h0);
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_sel", 16'(sel_n), 16'hF);
    chk("rst_seg", 16'(seg_data), 16'h7F);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_pending", 16'(pending), 16'h0);
    sys_rst_n = 1'b1;

    // 1: load 1234 at cycle 5, pending until boundary
    repeat (5) tick();
    data_in = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("t1_pending", 16'(pending), 16'h1);
    wait_fd(40);
    chk("t1_pending_at_fd", 16'(pending), 16'h1);
    tick();
    chk("t1_pending_cleared", 16'(pending), 16'h0);

    // 2: show 1234 while loading ABCD in slot 1; then ABCD
    frame_check({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                1, 16'hABCD, -1, 16'h0, 1'b0, 16'h0);
    chk("t2_pending_cleared", 16'(pending), 16'h0);
    lz_en = 1'b1;
    frame_check({7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001},
                2, 16'h0050, -1, 16'h0, 1'b0, 16'h0);

    // 3: leading-zero suppression
    frame_check({7'h7F, 7'h7F, 7'b0010010, 7'b1000000},
                0, 16'h0000, -1, 16'h0, 1'b0, 16'h0);
    frame_check({7'h7F, 7'h7F, 7'h7F, 7'b1000000},
                -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);

    // 4: digit enables; 6: load on frame boundary
    lz_en = 1'b0;
    digit_en = 4'b0101;
    frame_check({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                -1, 16'h0, -1, 16'h0, 1'b1, 16'h00F0);
    digit_en = 4'hF;
    // 6: two loads in one frame, last wins
    frame_check({7'b1000000, 7'b1000000, 7'b0001110, 7'b1000000},
                0, 16'h1111, 2, 16'h2222, 1'b0, 16'h0);
    frame_check({7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100},
                -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);

    // 5: reset during SHOW of digit 2
    data_in = 16'h3333;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("t5_pending_before_rst", 16'(pending), 16'h1);
    repeat (18) tick();
    chk("t5_pre_rst_sel", 16'(sel_n), 16'hB);
    chk("t5_pre_rst_seg", 16'(seg_data), 16'(7'b0100100));
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_sel", 16'(sel_n), 16'hF);
    chk("t5_rst_seg", 16'(seg_data), 16'h7F);
    chk("t5_rst_pending", 16'(pending), 16'h0);
    chk("t5_rst_frame_done", 16'(frame_done), 16'h0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    frame_check({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                -1, 16'h0, -1, 16'h0, 1'b0, 16'h0);
    chk("t5_final_pending", 16'(pending), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
